// File: rtl/video_luma_tracker_pkg.sv
// Shared constants for the luma tracker: BT.601 luma coefficients, rounding
// constant, default frame geometry and pipeline depth.
package video_luma_tracker_pkg;

    localparam int H_RES_DEF   = 800;
    localparam int V_RES_DEF   = 300;
    localparam int COORD_W_DEF = 11;

    // Coefficients sum to 256, so full-scale RGB maps to exactly 255.
    localparam logic [7:0]  COEF_R   = 8'd77;
    localparam logic [7:0]  COEF_G   = 8'd150;
    localparam logic [7:0]  COEF_B   = 8'd29;
    localparam logic [16:0] LUMA_RND = 17'd128;

    // Input-to-output latency; luma datapath and control delay line share it.
    localparam int PIPE_STAGES = 3;

endpackage

// File: rtl/video_luma_tracker_rgb_to_luma.sv
// RGB -> 8-bit BT.601 luma, 3-stage pipeline with no control.
//   S1: three 16-bit products
//   S2: 17-bit sum plus rounding constant
//   S3: sum[15:8]
// Ports:
//   hdmi_clk, rst        pixel clock, async active-high reset
//   r, g, b              8-bit input components
//   luma                 8-bit luma, 3 cycles after r/g/b
module video_luma_tracker_rgb_to_luma
    import video_luma_tracker_pkg::*;
(
    input  logic       hdmi_clk,
    input  logic       rst,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] luma
);

    logic [15:0] prod_r, prod_g, prod_b;
    logic [16:0] sum;

    always_ff @(posedge hdmi_clk or posedge rst) begin
        if (rst) begin
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
            sum    <= '0;
            luma   <= '0;
        end else begin
            prod_r <= 16'(r) * 16'(COEF_R);
            prod_g <= 16'(g) * 16'(COEF_G);
            prod_b <= 16'(b) * 16'(COEF_B);
            sum    <= 17'(prod_r) + 17'(prod_g) + 17'(prod_b) + LUMA_RND;
            // Max sum is 255*256+128, so bit 16 is never set and the
            // truncation to sum[15:8] needs no saturation.
            luma   <= 8'(sum >> 8);
        end
    end

endmodule

// File: rtl/video_luma_tracker.sv
// Raw HDMI pixel stream -> luma tagged with x/y coordinates, frame/line
// markers and geometry-error pulses, all delayed a fixed 3 cycles.
// Ports:
//   hdmi_clk, rst                   pixel clock, async active-high reset
//   hdmi_de/hs/vs                   input data enable and syncs (active-high)
//   hdmi_r/g/b                      input pixel components
//   luma                            BT.601 luma
//   de_o, hs_o, vs_o                delayed enable/syncs (de_o masked until synced)
//   x, y                            coordinates of the pixel on luma
//   frame_start, line_end           pixel (0,0) / last pixel of a line
//   line_err, frame_err             pulses for a bad line length / line count
module video_luma_tracker
    import video_luma_tracker_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               hdmi_clk,
    input  logic               rst,
    input  logic               hdmi_de,
    input  logic               hdmi_hs,
    input  logic               hdmi_vs,
    input  logic [7:0]         hdmi_r,
    input  logic [7:0]         hdmi_g,
    input  logic [7:0]         hdmi_b,
    output logic [7:0]         luma,
    output logic               de_o,
    output logic               hs_o,
    output logic               vs_o,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start,
    output logic               line_end,
    output logic               line_err,
    output logic               frame_err
);

    localparam logic [COORD_W-1:0] X_MAX  = '1;
    localparam logic [COORD_W-1:0] H_LEN  = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_RES - 1);
    localparam logic [COORD_W:0]   V_LEN  = (COORD_W + 1)'(V_RES);

    typedef struct packed {
        logic               de;
        logic               hs;
        logic               vs;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               fs;
        logic               le;
        logic               lerr;
        logic               ferr;
    } ctl_t;

    logic               de_q, vs_q, synced;
    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic               de_fall, vs_rise;
    logic [COORD_W:0]   line_cnt;
    ctl_t               ctl_in, ctl_out;
    ctl_t               ctl_pipe [PIPE_STAGES];

    // Everything but hs/vs is gated by synced so a frame entered mid-way
    // (after reset) stays silent until the next vsync.
    always_comb begin
        de_fall  = de_q & ~hdmi_de;
        vs_rise  = hdmi_vs & ~vs_q;
        // A line closing on the vsync edge still belongs to the old frame.
        line_cnt = {1'b0, y_cnt} + {{COORD_W{1'b0}}, de_fall};

        ctl_in      = '0;
        ctl_in.de   = hdmi_de & synced;
        ctl_in.hs   = hdmi_hs;
        ctl_in.vs   = hdmi_vs;
        ctl_in.x    = x_cnt;
        ctl_in.y    = y_cnt;
        ctl_in.fs   = hdmi_de & synced & (x_cnt == '0) & (y_cnt == '0);
        ctl_in.le   = hdmi_de & synced & (x_cnt == H_LAST);
        ctl_in.lerr = synced & de_fall & (x_cnt != H_LEN);
        ctl_in.ferr = synced & vs_rise & (line_cnt != V_LEN);
    end

    always_ff @(posedge hdmi_clk or posedge rst) begin
        if (rst) begin
            de_q   <= 1'b0;
            vs_q   <= 1'b0;
            synced <= 1'b0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else begin
            de_q <= hdmi_de;
            vs_q <= hdmi_vs;
            if (vs_rise)
                synced <= 1'b1;

            // Saturate so an overlong line keeps reporting a bad length
            // instead of wrapping back through H_RES.
            if (hdmi_de) begin
                if (x_cnt != X_MAX)
                    x_cnt <= x_cnt + 1'b1;
            end else if (de_fall) begin
                x_cnt <= '0;
            end

            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    always_ff @(posedge hdmi_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++)
                ctl_pipe[i] <= '0;
        end else begin
            ctl_pipe[0] <= ctl_in;
            for (int i = 1; i < PIPE_STAGES; i++)
                ctl_pipe[i] <= ctl_pipe[i-1];
        end
    end

    assign ctl_out     = ctl_pipe[PIPE_STAGES-1];
    assign de_o        = ctl_out.de;
    assign hs_o        = ctl_out.hs;
    assign vs_o        = ctl_out.vs;
    assign x           = ctl_out.x;
    assign y           = ctl_out.y;
    assign frame_start = ctl_out.fs;
    assign line_end    = ctl_out.le;
    assign line_err    = ctl_out.lerr;
    assign frame_err   = ctl_out.ferr;

    video_luma_tracker_rgb_to_luma u_luma (
        .hdmi_clk (hdmi_clk),
        .rst      (rst),
        .r        (hdmi_r),
        .g        (hdmi_g),
        .b        (hdmi_b),
        .luma     (luma)
    );

endmodule

// File: tb/tb_video_luma_tracker.sv
// Bench for video_luma_tracker on a 4x3 geometry. A per-cycle reference
// model (integer frame/line bookkeeping) predicts every output 3 cycles
// ahead; scenario-level event counts are also checked against fixed values.
module tb_video_luma_tracker;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int CW = 11;
    localparam int XSAT = (1 << CW) - 1;

    logic          hdmi_clk = 1'b0;
    logic          rst = 1'b1;
    logic          hdmi_de = 1'b0, hdmi_hs = 1'b0, hdmi_vs = 1'b0;
    logic [7:0]    hdmi_r = '0, hdmi_g = '0, hdmi_b = '0;
    logic [7:0]    luma;
    logic          de_o, hs_o, vs_o;
    logic [CW-1:0] x, y;
    logic          frame_start, line_end, line_err, frame_err;

    video_luma_tracker #(.H_RES(H), .V_RES(V), .COORD_W(CW)) dut (
        .hdmi_clk    (hdmi_clk),
        .rst         (rst),
        .hdmi_de     (hdmi_de),
        .hdmi_hs     (hdmi_hs),
        .hdmi_vs     (hdmi_vs),
        .hdmi_r      (hdmi_r),
        .hdmi_g      (hdmi_g),
        .hdmi_b      (hdmi_b),
        .luma        (luma),
        .de_o        (de_o),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .line_end    (line_end),
        .line_err    (line_err),
        .frame_err   (frame_err)
    );

    always #5 hdmi_clk = ~hdmi_clk;

    typedef struct {
        int luma, de, hs, vs, x, y, fs, le, lerr, ferr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // reference model state
    int m_prev_de, m_prev_vs, m_locked, m_pix, m_line;

    // observed event counts per scenario
    int n_de, n_fs, n_le, n_lerr, n_ferr;
    int luma_log[$];

    task automatic chk(string tag, int obs, int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_t z = '{default: 0};
        q.delete();
        q.push_back(z);
        q.push_back(z);
        m_prev_de = 0; m_prev_vs = 0; m_locked = 0; m_pix = 0; m_line = 0;
    endtask

    task automatic clr_cnt();
        n_de = 0; n_fs = 0; n_le = 0; n_lerr = 0; n_ferr = 0;
        luma_log.delete();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_luma"}, int'(luma), 0);
        chk({tag, "_ctl"}, int'({de_o, hs_o, vs_o, frame_start, line_end, line_err, frame_err}), 0);
        chk({tag, "_xy"}, int'(x) + int'(y), 0);
    endtask

    // One pixel-clock cycle of input; optionally pulse rst during it.
    task automatic step(bit de, bit hs, bit vs, int r, int g, int b, bit do_rst = 1'b0);
        exp_t e;
        bit   closes, opens;
        hdmi_de = de; hdmi_hs = hs; hdmi_vs = vs;
        hdmi_r = 8'(r); hdmi_g = 8'(g); hdmi_b = 8'(b);
        if (do_rst) begin
            rst = 1'b1;
            #1;
            chk_zero("rst_mid");
            model_reset();
            #1 rst = 1'b0;
        end
        closes = (m_prev_de != 0) && !de;
        opens  = vs && (m_prev_vs == 0);
        e.luma = (77 * r + 150 * g + 29 * b + 128) / 256;
        e.hs   = hs;
        e.vs   = vs;
        e.de   = (de && m_locked != 0) ? 1 : 0;
        e.x    = m_pix;
        e.y    = m_line;
        e.fs   = (e.de != 0 && m_pix == 0 && m_line == 0) ? 1 : 0;
        e.le   = (e.de != 0 && m_pix == H - 1) ? 1 : 0;
        e.lerr = (m_locked != 0 && closes && m_pix != H) ? 1 : 0;
        e.ferr = (m_locked != 0 && opens && (m_line + (closes ? 1 : 0)) != V) ? 1 : 0;
        q.push_back(e);
        if (de) m_pix = (m_pix < XSAT) ? m_pix + 1 : XSAT;
        if (closes) begin m_pix = 0; m_line++; end
        if (opens) begin m_line = 0; m_locked = 1; end
        m_prev_de = de;
        m_prev_vs = vs;

        @(posedge hdmi_clk);
        #1;
        e = q.pop_front();
        chk("de_o", int'(de_o), e.de);
        chk("hs_o", int'(hs_o), e.hs);
        chk("vs_o", int'(vs_o), e.vs);
        chk("luma", int'(luma), e.luma);
        chk("frame_start", int'(frame_start), e.fs);
        chk("line_end", int'(line_end), e.le);
        chk("line_err", int'(line_err), e.lerr);
        chk("frame_err", int'(frame_err), e.ferr);
        if (e.de != 0) begin
            chk("x", int'(x), e.x);
            chk("y", int'(y), e.y);
        end
        n_de += int'(de_o); n_fs += int'(frame_start); n_le += int'(line_end);
        n_lerr += int'(line_err); n_ferr += int'(frame_err);
        if (de_o) luma_log.push_back(int'(luma));
    endtask

    task automatic pix();
        step(1'b1, 1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic blank(bit vs_now);
        for (int i = 0; i < 4; i++)
            step(1'b0, (i == 1 || i == 2), vs_now && (i < 2), 0, 0, 0);
    endtask

    task automatic send_line(int n, bit vs_now = 1'b0);
        for (int i = 0; i < n; i++) pix();
        blank(vs_now);
    endtask

    task automatic vsync();
        step(1'b0, 1'b0, 1'b1, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic frame(int lines);
        for (int i = 0; i < lines; i++) send_line(H);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        // reset state
        #12;
        chk_zero("reset");
        rst = 1'b0;
        model_reset();
        clr_cnt();

        // 1: line before any vsync is masked; then one clean 4x3 frame
        send_line(H);
        drain();
        chk("pre_vs_de_count", n_de, 0);
        clr_cnt();
        vsync();
        frame(V);
        vsync();
        drain();
        chk("s1_de_count", n_de, H * V);
        chk("s1_frame_start_count", n_fs, 1);
        chk("s1_line_end_count", n_le, V);
        chk("s1_err_count", n_lerr + n_ferr, 0);

        // 2: directed colours, latency checked by the model queue
        clr_cnt();
        step(1'b1, 1'b0, 1'b0, 255, 255, 255);
        step(1'b1, 1'b0, 1'b0, 255, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 255, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 255);
        blank(1'b0);
        frame(V - 1);
        vsync();
        drain();
        chk("luma_white", luma_log[0], 255);
        chk("luma_red", luma_log[1], 77);
        chk("luma_green", luma_log[2], 149);
        chk("luma_blue", luma_log[3], 29);
        chk("s2_err_count", n_lerr + n_ferr, 0);

        // 3: short middle line
        clr_cnt();
        send_line(H);
        send_line(H - 1);
        send_line(H);
        vsync();
        drain();
        chk("s3_line_err_count", n_lerr, 1);
        chk("s3_frame_err_count", n_ferr, 0);
        chk("s3_line_end_count", n_le, 2);

        // 4: two-line frame, then a correct one
        clr_cnt();
        frame(2);
        vsync();
        drain();
        chk("s4_frame_err_short", n_ferr, 1);
        clr_cnt();
        frame(V);
        vsync();
        drain();
        chk("s4_frame_err_ok", n_ferr, 0);
        chk("s4_line_err_ok", n_lerr, 0);

        // 5: reset at pixel (2,1); rest of frame silent, next frame clean
        clr_cnt();
        send_line(H);
        pix();
        pix();
        step(1'b1, 1'b0, 1'b0, $urandom_range(0, 255), 7, 9, 1'b1);
        clr_cnt();
        pix();
        blank(1'b0);
        send_line(H);
        drain();
        chk("s5_post_rst_de_count", n_de, 0);
        chk("s5_post_rst_err_count", n_lerr + n_ferr, 0);
        vsync();
        frame(V);
        vsync();
        drain();
        chk("s5_de_count", n_de, H * V);
        chk("s5_frame_start_count", n_fs, 1);
        chk("s5_err_count", n_lerr + n_ferr, 0);

        // 6: de fall coincident with vs rise
        clr_cnt();
        frame(V - 1);
        send_line(H, 1'b1);
        chk("s6a_err_count", n_lerr + n_ferr, 0);
        clr_cnt();
        frame(V - 1);
        send_line(H - 1, 1'b1);
        chk("s6b_line_err_count", n_lerr, 1);
        chk("s6b_frame_err_count", n_ferr, 0);
        clr_cnt();
        send_line(H);
        send_line(H, 1'b1);
        drain();
        chk("s6c_line_err_count", n_lerr, 0);
        chk("s6c_frame_err_count", n_ferr, 1);
        clr_cnt();
        frame(V);
        vsync();
        drain();
        chk("s6d_frame_start_count", n_fs, 1);

        // 7: overlong line saturates x and still flags
        clr_cnt();
        send_line(XSAT + 3);
        frame(V - 1);
        vsync();
        drain();
        chk("s7_line_err_count", n_lerr, 1);
        chk("s7_frame_err_count", n_ferr, 0);

        // random geometry, checked cycle by cycle against the model
        for (int f = 0; f < 8; f++) begin
            int nl;
            nl = $urandom_range(2, 4);
            for (int l = 0; l < nl; l++) begin
                bit last_vs;
                last_vs = (l == nl - 1) && ($urandom_range(0, 1) == 1);
                send_line($urandom_range(0, 3) == 0 ? $urandom_range(2, 6) : H, last_vs);
                if (last_vs) break;
            end
            if (m_prev_vs == 0) vsync();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
